// File: rtl/pe_issue_sched.sv
// -----------------------------------------------------------------------------
// pe_issue_sched
//
// Issue scheduler for a processing-element datapath. It accepts one operation
// request per cycle and assigns it an issue slot. A result strobe comes back
// PIPE_DEPTH cycles after the slot. Credits from the downstream result buffer
// are tracked, and a mode change waits until the pipeline has drained.
//
// Handshake: a request transfers in exactly the cycles where req_valid and
// req_ready are both 1. req_ready is combinational on req_mode. The requester
// must keep req_valid and its payload stable until that transfer happens.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   req_valid/ready    request handshake
//   req_mode           00 fp16, 01 fp32, 10 fp64, 11 illegal
//   req_last           last operand of an accumulation group
//   req_tag            requester tag
//   mode_sel_pip0      datapath mode for the current slot (11 = bubble)
//   acc_clr            clear the accumulator on the current slot
//   res_valid/last/tag result strobe at the final pipeline stage
//   cred_return        one downstream buffer entry freed
//   dbg_state          FSM state (00 IDLE, 01 RUN, 10 FP64_HI, 11 DRAIN)
//   err_mode           one-cycle pulse when an illegal-mode request is consumed
//
// Optional feature: define PE_SCHED_PERF_EN to add perf_busy_cnt and
// perf_stall_cnt. These are saturating 32-bit counters of issue-slot cycles
// and of stalled-request cycles.
// -----------------------------------------------------------------------------
module pe_issue_sched #(
  parameter int PIPE_DEPTH = 3,
  parameter int CREDITS    = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_mode,
  input  logic       req_last,
  input  logic [3:0] req_tag,
  output logic [1:0] mode_sel_pip0,
  output logic       acc_clr,
  output logic       res_valid,
  output logic       res_last,
  output logic [3:0] res_tag,
  input  logic       cred_return,
  output logic [1:0] dbg_state,
  output logic       err_mode
`ifdef PE_SCHED_PERF_EN
  ,
  output logic [31:0] perf_busy_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int NW = $clog2(PIPE_DEPTH + 2);

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_RUN     = 2'b01;
  localparam logic [1:0] S_FP64_HI = 2'b10;
  localparam logic [1:0] S_DRAIN   = 2'b11;

  localparam logic [1:0] MODE_FP64   = 2'b10;
  localparam logic [1:0] MODE_BUBBLE = 2'b11;

  logic [1:0]               state, state_nxt;
  logic [1:0]               cur_mode;
  logic [CW-1:0]            credits, credits_nxt;
  logic                     acc_pend;
  logic [3:0]               hi_tag;
  logic                     hi_last;

  // Result pipeline: one {valid,tag,last} entry per stage.
  logic [PIPE_DEPTH-1:0]      sr_v;
  logic [PIPE_DEPTH-1:0]      sr_last;
  logic [PIPE_DEPTH-1:0][3:0] sr_tag;

  logic [NW-1:0] sr_cnt, sr_cnt_nxt, inflight;
  logic          req_legal, mode_ok, accept, accept_legal, cred_dec;
  logic          push_v, push_last;
  logic [3:0]    push_tag;

  // Count the occupied pipeline stages. The pending FP64_HI slot also counts as in flight.
  always_comb begin
    sr_cnt = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) sr_cnt = sr_cnt + NW'(sr_v[i]);
  end

  assign inflight = sr_cnt + NW'(state == S_FP64_HI);

  // An illegal-mode request never changes the datapath mode, so it does not
  // wait for a drain. It is consumed as soon as the scheduler can take requests.
  assign req_legal = (req_mode != MODE_BUBBLE);
  assign mode_ok   = !req_legal || (req_mode == cur_mode) || (inflight == '0);
  assign req_ready = rstn && ((state == S_IDLE) || (state == S_RUN)) &&
                     (credits != '0) && mode_ok;

  assign accept       = req_valid && req_ready;
  assign accept_legal = accept && req_legal;
  assign err_mode     = accept && !req_legal;
  assign acc_clr      = accept_legal && acc_pend;

  // An fp64 op occupies two slots. Its result entry is pushed on the second slot.
  always_comb begin
    push_v    = 1'b0;
    push_tag  = req_tag;
    push_last = req_last;
    if (state == S_FP64_HI) begin
      push_v    = 1'b1;
      push_tag  = hi_tag;
      push_last = hi_last;
    end else if (accept_legal && (req_mode != MODE_FP64)) begin
      push_v = 1'b1;
    end
  end

  always_comb begin
    mode_sel_pip0 = MODE_BUBBLE;
    if (state == S_FP64_HI)  mode_sel_pip0 = MODE_FP64;
    else if (accept_legal)   mode_sel_pip0 = req_mode;
  end

  // Pipeline occupancy after this edge: the last stage retires, and a push adds one.
  always_comb begin
    sr_cnt_nxt = NW'(push_v);
    for (int i = 0; i < PIPE_DEPTH - 1; i++) sr_cnt_nxt = sr_cnt_nxt + NW'(sr_v[i]);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RUN: begin
        if (accept_legal) begin
          state_nxt = (req_mode == MODE_FP64) ? S_FP64_HI : S_RUN;
        end else if (req_valid && req_legal && (req_mode != cur_mode) &&
                     (inflight != '0)) begin
          state_nxt = S_DRAIN;
        end else if (sr_cnt_nxt == '0) begin
          state_nxt = S_IDLE;
        end
      end
      S_FP64_HI: state_nxt = S_RUN;
      S_DRAIN:   if (sr_cnt_nxt == '0) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // If a credit is consumed and one is returned in the same cycle, the two cancel.
  // A return arriving while the count is already full is dropped.
  assign cred_dec = accept_legal && req_last;
  always_comb begin
    credits_nxt = credits;
    if (cred_dec && !cred_return) begin
      credits_nxt = credits - CW'(1);
    end else if (!cred_dec && cred_return && (credits != CW'(CREDITS))) begin
      credits_nxt = credits + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      cur_mode <= 2'b00;
      credits  <= CW'(CREDITS);
      acc_pend <= 1'b1;
      hi_tag   <= 4'h0;
      hi_last  <= 1'b0;
      sr_v     <= '0;
      sr_last  <= '0;
      sr_tag   <= '0;
    end else begin
      state   <= state_nxt;
      credits <= credits_nxt;
      if (accept_legal) begin
        cur_mode <= req_mode;
        acc_pend <= req_last;
      end
      if (accept_legal && (req_mode == MODE_FP64)) begin
        hi_tag  <= req_tag;
        hi_last <= req_last;
      end
      sr_v[0]    <= push_v;
      sr_tag[0]  <= push_tag;
      sr_last[0] <= push_last;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        sr_v[i]    <= sr_v[i-1];
        sr_tag[i]  <= sr_tag[i-1];
        sr_last[i] <= sr_last[i-1];
      end
    end
  end

  assign res_valid = sr_v[PIPE_DEPTH-1];
  assign res_last  = sr_last[PIPE_DEPTH-1];
  assign res_tag   = sr_tag[PIPE_DEPTH-1];
  assign dbg_state = state;

`ifdef PE_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_busy_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if ((mode_sel_pip0 != MODE_BUBBLE) && (perf_busy_cnt != '1))
        perf_busy_cnt <= perf_busy_cnt + 32'd1;
      if (req_valid && !req_ready && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
